// File: rtl/approx_err_monitor_pkg.sv
// Shared widths and FSM encoding for the approximate-adder error monitor.
package approx_err_monitor_pkg;
  localparam int OP_W  = 8;
  localparam int SUM_W = 9;
  localparam int CNT_W = 16;
  localparam int ACC_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/approx_err_monitor_err_distance.sv
// Combinational error distance between the exact sum a+b and an approximate sum.
module err_distance
  import approx_err_monitor_pkg::*;
(
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  input  logic [SUM_W-1:0] approx_sum_i,
  output logic [SUM_W-1:0] ed_o,
  output logic             ne_o
);
  logic [SUM_W-1:0] exact;

  assign exact = {1'b0, a_i} + {1'b0, b_i};
  assign ed_o  = (exact >= approx_sum_i) ? (exact - approx_sum_i) : (approx_sum_i - exact);
  assign ne_o  = (exact != approx_sum_i);
endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error statistics for an upstream approximate adder.
// Define APPROX_MAX_ED_EN to build the max error distance tracker.
module approx_err_monitor
  import approx_err_monitor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [SUM_W-1:0] approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [SUM_W-1:0] max_ed
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, cnt_q, cnt_d, err_q, err_d, cnt_inc;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W:0]   sum_ext;
  logic [SUM_W-1:0] ed;
  logic             ne, accept;

  err_distance u_ed (
    .a_i          (a),
    .b_i          (b),
    .approx_sum_i (approx_sum),
    .ed_o         (ed),
    .ne_o         (ne)
  );

  // Handshake and status are pure state decodes, so no input reaches them combinationally.
  assign in_ready = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = cnt_q + 16'd1;
  assign sum_ext  = {1'b0, sum_q} + {{(ACC_W+1-SUM_W){1'b0}}, ed};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: if (start) begin
        n_d     = n_samples;
        cnt_d   = '0;
        err_d   = '0;
        sum_d   = '0;
        state_d = (n_samples != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: if (accept) begin
        cnt_d = cnt_inc;
        if (ne && (err_q != '1)) err_d = err_q + 16'd1;
        sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        if (cnt_inc == n_q) state_d = ST_DONE;
      end
      ST_DONE: if (clear) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
    end
  end

  assign err_count = err_q;
  assign sum_ed    = sum_q;

`ifdef APPROX_MAX_ED_EN
  logic [SUM_W-1:0] max_q, max_d;
  logic             clr_acc;

  assign clr_acc = (state_q == ST_IDLE) && start;

  always_comb begin
    max_d = max_q;
    if (clr_acc) max_d = '0;
    else if (accept && (ed > max_q)) max_d = ed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) max_q <= '0;
    else     max_q <= max_d;
  end

  assign max_ed = max_q;
`else
  assign max_ed = '0;
`endif
endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench: each window pushes its expected results; a monitor checks them when done rises.
module tb_approx_err_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [15:0] n_samples = '0;
  logic [7:0]  a = '0, b = '0;
  logic [8:0]  approx_sum = '0;
  logic        in_ready, busy, done;
  logic [15:0] err_count;
  logic [23:0] sum_ed;
  logic [8:0]  max_ed;

`ifdef APPROX_MAX_ED_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  typedef struct {
    logic [15:0] err;
    logic [23:0] sum;
    logic [8:0]  mx;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0;

  approx_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx_sum(approx_sum),
    .busy(busy), .done(done), .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  // Monitor: on each rising edge of done, pop and compare one window result.
  initial begin
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_err"}, 32'(err_count), 32'(e.err));
          check({e.name, "_sum"}, 32'(sum_ed), 32'(e.sum));
          check({e.name, "_max"}, 32'(max_ed), 32'(MAXEN ? e.mx : 9'd0));
        end
      end
      done_prev = done;
    end
  end

  task automatic push(input string name, input logic [15:0] err, input logic [23:0] sum,
                      input logic [8:0] mx);
    exp_t e;
    e.name = name; e.err = err; e.sum = sum; e.mx = mx;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] n);
    @(negedge clk);
    start = 1'b1; n_samples = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic [8:0] ss);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; a = sa; b = sb; approx_sum = ss;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic [7:0] sa, input logic [7:0] sb, input logic [8:0] ss);
    @(negedge clk);
    in_valid = 1'b0; a = sa; b = sb; approx_sum = ss;
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    // reset state
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // basic window: ED 2, 0, 4
    push("w3", 16'd2, 24'd6, 9'd4);
    do_start(16'd3);
    check("w3_busy", 32'(busy), 32'd1);
    send(8'h0F, 8'h01, 9'h00E);
    send(8'h10, 8'h20, 9'h030);
    send(8'h03, 8'h03, 9'h002);
    check("w3_done_next", 32'(done), 32'd1);
    check("w3_ready_low", 32'(in_ready), 32'd0);
    do_clear();
    check("clr_done", 32'(done), 32'd0);
    check("clr_hold_err", 32'(err_count), 32'd2);
    check("clr_hold_sum", 32'(sum_ed), 32'd6);

    // exact samples including the 0x1FE carry case
    push("w2exact", 16'd0, 24'd0, 9'd0);
    do_start(16'd2);
    send(8'h08, 8'h08, 9'h010);
    send(8'hFF, 8'hFF, 9'h1FE);
    do_clear();

    // zero-length window
    push("w0", 16'd0, 24'd0, 9'd0);
    do_start(16'd0);
    check("w0_done", 32'(done), 32'd1);
    check("w0_busy", 32'(busy), 32'd0);
    check("w0_ready", 32'(in_ready), 32'd0);
    // start and clear together in DONE: clear wins
    @(negedge clk);
    start = 1'b1; clear = 1'b1; n_samples = 16'd5;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    check("sc_busy", 32'(busy), 32'd0);
    check("sc_done", 32'(done), 32'd0);

    // gaps in in_valid, garbage on invalid cycles, start pulse in RUN
    push("gap", 16'd2, 24'd6, 9'd4);
    do_start(16'd2);
    send(8'h0F, 8'h01, 9'h00E);
    @(negedge clk);
    a = 8'h00; b = 8'h00; approx_sum = 9'h1FF; start = 1'b1; n_samples = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("gap_still_busy", 32'(busy), 32'd1);
    idle_cycle(8'h00, 8'h00, 9'h1FF);
    send(8'h03, 8'h03, 9'h002);
    idle_cycle(8'h00, 8'h00, 9'h1FF);
    check("gap_done", 32'(done), 32'd1);
    do_clear();

    // reset mid-window
    do_start(16'd4);
    send(8'h03, 8'h03, 9'h002);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd0);
    check("mrst_err", 32'(err_count), 32'd0);
    check("mrst_sum", 32'(sum_ed), 32'd0);
    check("mrst_max", 32'(max_ed), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    push("after_rst", 16'd1, 24'd4, 9'd4);
    do_start(16'd1);
    send(8'h03, 8'h03, 9'h002);
    do_clear();

    // sum_ed saturation: 32900 * 511 exceeds 2^24-1
    push("sat", 16'd32900, 24'hFFFFFF, 9'd511);
    do_start(16'd32900);
    @(negedge clk);
    in_valid = 1'b1; a = 8'h00; b = 8'h00; approx_sum = 9'h1FF;
    t = 0;
    while (!done && t < 40000) begin @(negedge clk); t++; end
    in_valid = 1'b0;
    if (t >= 40000) check("sat_timeout", 32'd0, 32'd1);
    do_clear();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
